// File: rtl/etapa_ejecucion.sv
// Execute stage: single-cycle ALU plus a DATA_W-iteration shift-add multiplier, feeding the register bank write port.
// Optional build macro EXEC_OVF_EN adds the OVF output and suppresses the write of signed-overflowing ADD/SUB results.
module etapa_ejecucion #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [2:0]        OP,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [ADDR_W-1:0] AW_IN,
  output logic              BUSY,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [ADDR_W-1:0] AW_OUT,
  output logic              WRITEREG_OUT,
`ifdef EXEC_OVF_EN
  output logic              OVF,
`endif
  output logic              ZERO
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_PAS = 3'b111;

  typedef enum logic [0:0] {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   mplier;
  logic [DATA_W-1:0]   acc;
  logic [ADDR_W-1:0]   aw_lat;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]   acc_next;
  logic                alu_wr;

  assign sum  = A + B;
  assign diff = A - B;

  // Combinational ALU result for single-cycle operations
  always_comb begin
    alu_res = {DATA_W{1'b0}};
    case (OP)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL:  alu_res = A << B[4:0];
      OP_PAS:  alu_res = A;
      default: alu_res = {DATA_W{1'b0}};
    endcase
  end

`ifdef EXEC_OVF_EN
  logic alu_ovf;

  // Signed overflow detection for ADD/SUB
  always_comb begin
    alu_ovf = 1'b0;
    if (OP == OP_ADD) begin
      alu_ovf = (A[DATA_W-1] == B[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
    end else if (OP == OP_SUB) begin
      alu_ovf = (A[DATA_W-1] != B[DATA_W-1]) && (diff[DATA_W-1] != A[DATA_W-1]);
    end else begin
      alu_ovf = 1'b0;
    end
  end

  assign alu_wr = (AW_IN != {ADDR_W{1'b0}}) && !alu_ovf;
`else
  assign alu_wr = (AW_IN != {ADDR_W{1'b0}});
`endif

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  // Control FSM, multiplier datapath and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      cnt          <= {CNT_W{1'b0}};
      mcand        <= {DATA_W{1'b0}};
      mplier       <= {DATA_W{1'b0}};
      acc          <= {DATA_W{1'b0}};
      aw_lat       <= {ADDR_W{1'b0}};
      BUSY         <= 1'b0;
      DATA_OUT     <= {DATA_W{1'b0}};
      AW_OUT       <= {ADDR_W{1'b0}};
      WRITEREG_OUT <= 1'b0;
      ZERO         <= 1'b0;
`ifdef EXEC_OVF_EN
      OVF          <= 1'b0;
`endif
    end else begin
      WRITEREG_OUT <= 1'b0;
`ifdef EXEC_OVF_EN
      OVF          <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (START && (OP == OP_MUL)) begin
            mcand  <= A;
            mplier <= B;
            aw_lat <= AW_IN;
            acc    <= {DATA_W{1'b0}};
            cnt    <= {CNT_W{1'b0}};
            BUSY   <= 1'b1;
            state  <= MUL_RUN;
          end else if (START) begin
            DATA_OUT     <= alu_res;
            ZERO         <= (alu_res == {DATA_W{1'b0}});
            AW_OUT       <= AW_IN;
            WRITEREG_OUT <= alu_wr;
`ifdef EXEC_OVF_EN
            OVF          <= alu_ovf;
`endif
          end else begin
            BUSY <= 1'b0;
          end
        end
        MUL_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          // Last iteration: publish the product and return to IDLE on this same edge
          if (cnt == CNT_W'(DATA_W-1)) begin
            DATA_OUT     <= acc_next;
            ZERO         <= (acc_next == {DATA_W{1'b0}});
            AW_OUT       <= aw_lat;
            WRITEREG_OUT <= (aw_lat != {ADDR_W{1'b0}});
            BUSY         <= 1'b0;
            cnt          <= {CNT_W{1'b0}};
            state        <= IDLE;
          end else begin
            BUSY <= 1'b1;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_etapa_ejecucion.sv
// Directed self-checking bench for etapa_ejecucion; drives on the falling edge and samples on the next falling edge.
module tb_etapa_ejecucion;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [2:0]  OP;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  AW_IN;
  logic        BUSY;
  logic [31:0] DATA_OUT;
  logic [4:0]  AW_OUT;
  logic        WRITEREG_OUT;
  logic        ZERO;
`ifdef EXEC_OVF_EN
  logic        OVF;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  etapa_ejecucion #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .START(START),
    .OP(OP),
    .A(A),
    .B(B),
    .AW_IN(AW_IN),
    .BUSY(BUSY),
    .DATA_OUT(DATA_OUT),
    .AW_OUT(AW_OUT),
    .WRITEREG_OUT(WRITEREG_OUT),
`ifdef EXEC_OVF_EN
    .OVF(OVF),
`endif
    .ZERO(ZERO)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one single-cycle op and check the result on the following cycle
  task automatic alu_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] aw,
                        input logic [31:0] exp, input logic exp_wr);
    @(negedge CLK);
    START = 1'b1; OP = op; A = a; B = b; AW_IN = aw;
    @(negedge CLK);
    START = 1'b0;
    check({tag, "_data"}, DATA_OUT, exp);
    check({tag, "_zero"}, {31'd0, ZERO}, {31'd0, (exp == 32'd0)});
    check({tag, "_aw"}, {27'd0, AW_OUT}, {27'd0, aw});
    check({tag, "_wr"}, {31'd0, WRITEREG_OUT}, {31'd0, exp_wr});
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; OP = 3'd0; A = 32'd0; B = 32'd0; AW_IN = 5'd0;
    #12;
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_data", DATA_OUT, 32'd0);
    check("rst_aw", {27'd0, AW_OUT}, 32'd0);
    check("rst_wr", {31'd0, WRITEREG_OUT}, 32'd0);
    check("rst_zero", {31'd0, ZERO}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // ADD 7+5 and one-cycle strobe
    alu_op("add", 3'b000, 32'h7, 32'h5, 5'd3, 32'hC, 1'b1);
    @(negedge CLK);
    check("add_wr_drop", {31'd0, WRITEREG_OUT}, 32'd0);
    check("add_hold", DATA_OUT, 32'hC);

    // Back-to-back SUB then SLT
    @(negedge CLK);
    START = 1'b1; OP = 3'b001; A = 32'd5; B = 32'd5; AW_IN = 5'd4;
    @(negedge CLK);
    check("b2b_sub_data", DATA_OUT, 32'd0);
    check("b2b_sub_zero", {31'd0, ZERO}, 32'd1);
    check("b2b_sub_wr", {31'd0, WRITEREG_OUT}, 32'd1);
    OP = 3'b100; A = 32'hFFFF_FFFF; B = 32'd1; AW_IN = 5'd6;
    @(negedge CLK);
    START = 1'b0;
    check("b2b_slt_data", DATA_OUT, 32'd1);
    check("b2b_slt_aw", {27'd0, AW_OUT}, 32'd6);
    check("b2b_slt_wr", {31'd0, WRITEREG_OUT}, 32'd1);
    check("b2b_slt_zero", {31'd0, ZERO}, 32'd0);

    alu_op("and", 3'b010, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd1, 32'hF0F0_0000, 1'b1);
    alu_op("or", 3'b011, 32'h0000_000F, 32'h0000_00F0, 5'd2, 32'h0000_00FF, 1'b1);
    alu_op("sll", 3'b110, 32'h1, 32'h23, 5'd5, 32'h8, 1'b1);
    alu_op("pass", 3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31, 32'hDEAD_BEEF, 1'b1);
    alu_op("slt_neg", 3'b100, 32'h1, 32'hFFFF_FFFF, 5'd7, 32'd0, 1'b1);
    alu_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1, 5'd8, 32'd0, 1'b1);
    alu_op("sub_wrap", 3'b001, 32'h0, 32'h1, 5'd8, 32'hFFFF_FFFF, 1'b1);

    // MUL 1234*5678 with START held and operands changing mid-run
    @(negedge CLK);
    START = 1'b1; OP = 3'b101; A = 32'd1234; B = 32'd5678; AW_IN = 5'd9;
    @(negedge CLK);
    check("mul_busy0", {31'd0, BUSY}, 32'd1);
    check("mul_wr0", {31'd0, WRITEREG_OUT}, 32'd0);
    OP = 3'b000; A = 32'd111; B = 32'd222; AW_IN = 5'd7;
    for (int i = 1; i < 32; i++) begin
      @(negedge CLK);
      check("mul_busy", {31'd0, BUSY}, 32'd1);
      check("mul_wr_idle", {31'd0, WRITEREG_OUT}, 32'd0);
      if (i == 31) START = 1'b0;
    end
    @(negedge CLK);
    check("mul_done_busy", {31'd0, BUSY}, 32'd0);
    check("mul_data", DATA_OUT, 32'd7006652);
    check("mul_aw", {27'd0, AW_OUT}, 32'd9);
    check("mul_wr", {31'd0, WRITEREG_OUT}, 32'd1);
    check("mul_zero", {31'd0, ZERO}, 32'd0);
    @(negedge CLK);
    check("mul_wr_drop", {31'd0, WRITEREG_OUT}, 32'd0);
    check("mul_hold", DATA_OUT, 32'd7006652);

    // MUL with a zero operand raises ZERO
    @(negedge CLK);
    START = 1'b1; OP = 3'b101; A = 32'd0; B = 32'd77; AW_IN = 5'd10;
    @(negedge CLK);
    START = 1'b0;
    repeat (32) @(negedge CLK);
    check("mul0_data", DATA_OUT, 32'd0);
    check("mul0_zero", {31'd0, ZERO}, 32'd1);
    check("mul0_wr", {31'd0, WRITEREG_OUT}, 32'd1);

    // Register 0 destination: result updates, no strobe
    alu_op("aw0", 3'b000, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0);

    // Signed overflow on ADD
`ifdef EXEC_OVF_EN
    alu_op("ovf", 3'b000, 32'h7FFF_FFFF, 32'h1, 5'd11, 32'h8000_0000, 1'b0);
    check("ovf_flag", {31'd0, OVF}, 32'd1);
    @(negedge CLK);
    check("ovf_drop", {31'd0, OVF}, 32'd0);
`else
    alu_op("ovf", 3'b000, 32'h7FFF_FFFF, 32'h1, 5'd11, 32'h8000_0000, 1'b1);
`endif

    // Reset asserted during MUL iteration 10
    @(negedge CLK);
    START = 1'b1; OP = 3'b101; A = 32'd3; B = 32'd4; AW_IN = 5'd12;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    check("pre_rst_busy", {31'd0, BUSY}, 32'd1);
    #1 RST_N = 1'b0;
    #1;
    check("arst_busy", {31'd0, BUSY}, 32'd0);
    check("arst_data", DATA_OUT, 32'd0);
    check("arst_aw", {27'd0, AW_OUT}, 32'd0);
    check("arst_wr", {31'd0, WRITEREG_OUT}, 32'd0);
    check("arst_zero", {31'd0, ZERO}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      check("post_rst_wr", {31'd0, WRITEREG_OUT}, 32'd0);
      check("post_rst_busy", {31'd0, BUSY}, 32'd0);
    end

    // Block is usable again after the abort
    alu_op("post_rst_add", 3'b000, 32'd10, 32'd20, 5'd13, 32'd30, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
